// File: rtl/updown_mod_counter_pkg.sv
// Shared definitions for the up/down modulo counter.
// Mode command encoding on the 2-bit `state` input.
package updown_mod_counter_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_RUN   = 2'b10,
    ST_LOAD  = 2'b11
  } mode_e;

  // Width of the prescaler phase counter; covers PRESC_DIV up to 2^20-1.
  localparam int unsigned PRESC_CW = 20;

endpackage

// File: rtl/updown_mod_counter_prescaler.sv
// count_prescaler: free-running divide-by-PRESC_DIV.
// `tick` is high in the cycle where the phase counter sits on its last value.
// Dropping `en` clears the phase counter, which discards any partial period.
module count_prescaler
  import updown_mod_counter_pkg::*;
#(
  parameter int unsigned PRESC_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [PRESC_CW-1:0] LAST = PRESC_CW'(PRESC_DIV - 1);

  logic [PRESC_CW-1:0] phase;

  // Phase counter: runs 0..PRESC_DIV-1 while enabled, held at 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      phase <= '0;
    end else if (phase == LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign tick = en && (phase == LAST);

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with hold/clear/run/load modes,
// runtime terminal value and a one-cycle registered roll pulse on wrap.
// Build option: define UPDOWN_MOD_COUNTER_PRESCALE_EN to advance only once
// every PRESC_DIV cycles while in RUN; otherwise RUN advances every cycle.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned PRESC_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ud,
  input  logic [1:0]       state,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             roll
);

  // Reject an out-of-range divide ratio at elaboration.
  if (PRESC_DIV < 1 || PRESC_DIV > (1 << PRESC_CW) - 1) begin : g_bad_presc
    $error("updown_mod_counter: PRESC_DIV out of range 1..2^20-1");
  end

  mode_e            mode;
  logic             advance;
  logic [WIDTH-1:0] count_d;
  logic             roll_d;

  assign mode = mode_e'(state);

`ifdef UPDOWN_MOD_COUNTER_PRESCALE_EN
  count_prescaler #(
    .PRESC_DIV(PRESC_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (mode == ST_RUN),
    .tick(advance)
  );
`else
  assign advance = 1'b1;
`endif

  // Next count and roll from mode, direction and terminal value.
  always_comb begin
    count_d = count;
    roll_d  = 1'b0;
    case (mode)
      ST_HOLD:  count_d = count;
      ST_CLEAR: count_d = '0;
      ST_LOAD:  count_d = (load_val > max_val) ? max_val : load_val;
      ST_RUN: begin
        if (advance) begin
          if (ud) begin
            // Up: anything at or past the terminal wraps to zero.
            if (count >= max_val) begin
              count_d = '0;
              roll_d  = 1'b1;
            end else begin
              count_d = count + 1'b1;
            end
          end else begin
            // Down: zero wraps to the terminal; a count left above a lowered
            // terminal is pulled back to it without a roll.
            if (count == '0) begin
              count_d = max_val;
              roll_d  = 1'b1;
            end else if (count > max_val) begin
              count_d = max_val;
            end else begin
              count_d = count - 1'b1;
            end
          end
        end
      end
      default: count_d = count;
    endcase
  end

  // Count and roll registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      roll  <= 1'b0;
    end else begin
      count <= count_d;
      roll  <= roll_d;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed, table-driven bench for updown_mod_counter (WIDTH=7).
// Default build checks the per-cycle behaviour; with
// UPDOWN_MOD_COUNTER_PRESCALE_EN defined it checks the divide-by-4 timing.
module tb_updown_mod_counter;

  localparam int W = 7;
`ifdef UPDOWN_MOD_COUNTER_PRESCALE_EN
  localparam int unsigned P_DIV = 4;
`else
  localparam int unsigned P_DIV = 1;
`endif

  localparam logic [1:0] HOLD  = 2'b00;
  localparam logic [1:0] CLEAR = 2'b01;
  localparam logic [1:0] RUN   = 2'b10;
  localparam logic [1:0] LOAD  = 2'b11;

  typedef struct {
    logic         rst;
    logic [1:0]   st;
    logic         ud;
    logic [W-1:0] ld;
    logic [W-1:0] mx;
    logic [W-1:0] exp_count;
    logic         exp_roll;
  } vec_t;

  // clock / reset and DUT signals
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ud = 1'b1;
  logic [1:0]   state = RUN;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] max_val = 7'd99;
  logic [W-1:0] count;
  logic         roll;

  always #5 clk = ~clk;

  updown_mod_counter #(
    .WIDTH    (W),
    .PRESC_DIV(P_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ud      (ud),
    .state   (state),
    .load_val(load_val),
    .max_val (max_val),
    .count   (count),
    .roll    (roll)
  );

  // scoreboard: expected {roll, count} per applied cycle
  logic [W:0] exp_q[$];
  vec_t       vecs[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic add(input logic r, input logic [1:0] s, input logic u,
                     input logic [W-1:0] l, input logic [W-1:0] m,
                     input logic [W-1:0] ec, input logic er);
    vec_t v;
    v.rst = r; v.st = s; v.ud = u; v.ld = l; v.mx = m;
    v.exp_count = ec; v.exp_roll = er;
    vecs.push_back(v);
  endtask

  // driver: apply one cycle of inputs, then compare after the edge
  task automatic step(input string name, input vec_t v);
    logic [W:0] e;
    rst = v.rst; state = v.st; ud = v.ud; load_val = v.ld; max_val = v.mx;
    exp_q.push_back({v.exp_roll, v.exp_count});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (count !== e[W-1:0]) begin
      n_fail++;
      $display("FAIL %s count: got %0d expected %0d", name, count, e[W-1:0]);
    end
    n_tests++;
    if (roll !== e[W]) begin
      n_fail++;
      $display("FAIL %s roll: got %0d expected %0d", name, roll, e[W]);
    end
  endtask

  initial begin
`ifdef UPDOWN_MOD_COUNTER_PRESCALE_EN
    // reset, then RUN up: advance on every 4th RUN edge
    add(1, RUN, 1, 0, 99, 0, 0);
    add(1, RUN, 1, 0, 99, 0, 0);
    add(0, RUN, 1, 0, 99, 0, 0);
    add(0, RUN, 1, 0, 99, 0, 0);
    add(0, RUN, 1, 0, 99, 0, 0);
    add(0, RUN, 1, 0, 99, 1, 0);
    add(0, RUN, 1, 0, 99, 1, 0);
    add(0, RUN, 1, 0, 99, 1, 0);
    add(0, RUN, 1, 0, 99, 1, 0);
    add(0, RUN, 1, 0, 99, 2, 0);
    // two RUN edges, HOLD discards the partial period
    add(0, RUN, 1, 0, 99, 2, 0);
    add(0, RUN, 1, 0, 99, 2, 0);
    add(0, HOLD, 1, 0, 99, 2, 0);
    add(0, RUN, 1, 0, 99, 2, 0);
    add(0, RUN, 1, 0, 99, 2, 0);
    add(0, RUN, 1, 0, 99, 2, 0);
    add(0, RUN, 1, 0, 99, 3, 0);
    // LOAD is not gated by the prescaler
    add(0, LOAD, 1, 99, 99, 99, 0);
    add(0, RUN, 1, 0, 99, 99, 0);
    add(0, RUN, 1, 0, 99, 99, 0);
    add(0, RUN, 1, 0, 99, 99, 0);
    add(0, RUN, 1, 0, 99, 0, 1);
    add(0, RUN, 1, 0, 99, 0, 0);
`else
    // reset held 2 cycles in RUN, then count up from 0
    add(1, RUN, 1, 0, 99, 0, 0);
    add(1, RUN, 1, 0, 99, 0, 0);
    add(0, RUN, 1, 0, 99, 1, 0);
    add(0, RUN, 1, 0, 99, 2, 0);
    add(0, RUN, 1, 0, 99, 3, 0);
    // up wrap at 99
    add(0, LOAD, 1, 98, 99, 98, 0);
    add(0, RUN, 1, 0, 99, 99, 0);
    add(0, RUN, 1, 0, 99, 0, 1);
    add(0, RUN, 1, 0, 99, 1, 0);
    // down wrap, then clamp to lowered terminal
    add(0, LOAD, 0, 0, 9, 0, 0);
    add(0, RUN, 0, 0, 9, 9, 1);
    add(0, RUN, 0, 0, 5, 5, 0);
    add(0, RUN, 0, 0, 5, 4, 0);
    // load clamp, hold, clear, max_val=0
    add(0, LOAD, 1, 120, 99, 99, 0);
    add(0, HOLD, 1, 3, 99, 99, 0);
    add(0, HOLD, 0, 7, 99, 99, 0);
    add(0, HOLD, 1, 0, 50, 99, 0);
    add(0, HOLD, 0, 1, 99, 99, 0);
    add(0, HOLD, 1, 0, 99, 99, 0);
    add(0, CLEAR, 1, 55, 99, 0, 0);
    add(0, RUN, 1, 0, 0, 0, 1);
    add(0, RUN, 0, 0, 0, 0, 1);
    add(0, RUN, 1, 0, 0, 0, 1);
    // direction flip
    add(0, LOAD, 1, 10, 99, 10, 0);
    add(0, RUN, 1, 0, 99, 11, 0);
    add(0, RUN, 1, 0, 99, 12, 0);
    add(0, RUN, 1, 0, 99, 13, 0);
    add(0, RUN, 1, 0, 99, 14, 0);
    add(0, RUN, 0, 0, 99, 13, 0);
    add(0, RUN, 0, 0, 99, 12, 0);
    // reset mid-RUN, then down from 0 wraps to max
    add(1, RUN, 0, 0, 99, 0, 0);
    add(0, RUN, 0, 0, 99, 99, 1);
    add(0, HOLD, 0, 0, 99, 99, 0);
    // top of range: 127 with max 127
    add(0, LOAD, 1, 127, 127, 127, 0);
    add(0, RUN, 1, 0, 127, 0, 1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

`ifndef UPDOWN_MOD_COUNTER_PRESCALE_EN
    // hand-written: max_val=3 run-up, roll exactly once per 4-cycle period
    begin
      logic [W-1:0] seq [10];
      logic         rseq[10];
      vec_t v;
      seq  = '{7'd1, 7'd2, 7'd3, 7'd0, 7'd1, 7'd2, 7'd3, 7'd0, 7'd1, 7'd2};
      rseq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      v.rst = 0; v.st = CLEAR; v.ud = 1; v.ld = 0; v.mx = 3;
      v.exp_count = 0; v.exp_roll = 0;
      step("mod4_clear", v);
      for (int k = 0; k < 10; k++) begin
        v.st = RUN;
        v.exp_count = seq[k];
        v.exp_roll = rseq[k];
        step($sformatf("mod4_%0d", k), v);
      end
      // hand-written: mod-4 down from 2 wraps to 3 with roll, then 2
      v.st = LOAD; v.ld = 2; v.exp_count = 2; v.exp_roll = 0;
      step("mod4_dn_load", v);
      v.st = RUN; v.ud = 0; v.exp_count = 1; v.exp_roll = 0;
      step("mod4_dn_1", v);
      v.exp_count = 0; v.exp_roll = 0;
      step("mod4_dn_0", v);
      v.exp_count = 3; v.exp_roll = 1;
      step("mod4_dn_wrap", v);
      v.exp_count = 2; v.exp_roll = 0;
      step("mod4_dn_2", v);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
